// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: streams sequential ROM words into a small FIFO
// and flushes/redirects on branch. ROM reads are combinational (same-cycle data).
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce,
  output logic [31:0]              rom_addr,
  input  logic [31:0]              rom_inst,
  input  logic                     branch_flag,
  input  logic [31:0]              branch_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   mem_pc_r   [DEPTH];
  logic [31:0]   mem_inst_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          pop_s;
  logic          push_s;
  logic          valid_s;

  // Handshake decode; a full FIFO still accepts a fetch when the head drains.
  always_comb begin
    valid_s = 1'b0;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    if (rst) begin
      valid_s = (count_r != {CW{1'b0}});
      pop_s   = valid_s & out_ready;
      push_s  = ~branch_flag & ((count_r < DEPTH_C) | pop_s);
    end else begin
      valid_s = 1'b0;
      pop_s   = 1'b0;
      push_s  = 1'b0;
    end
  end

  // Output drive; everything reads as zero while reset is held or the FIFO is empty.
  always_comb begin
    rom_ce     = push_s;
    rom_addr   = 32'h0000_0000;
    out_valid  = valid_s;
    out_pc     = 32'h0000_0000;
    out_inst   = 32'h0000_0000;
    fifo_count = {CW{1'b0}};
    if (push_s) begin
      rom_addr = fetch_pc_r;
    end else begin
      rom_addr = 32'h0000_0000;
    end
    if (valid_s) begin
      out_pc     = mem_pc_r[rd_ptr_r];
      out_inst   = mem_inst_r[rd_ptr_r];
      fifo_count = count_r;
    end else begin
      out_pc     = 32'h0000_0000;
      out_inst   = 32'h0000_0000;
      fifo_count = {CW{1'b0}};
    end
  end

  // FIFO storage; deliberately not reset, only pointers and count are.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_pc_r[wr_ptr_r]   <= fetch_pc_r;
      mem_inst_r[wr_ptr_r] <= rom_inst;
    end
  end

  // Fetch PC, pointers and occupancy; branch outranks any handshake in its cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else if (branch_flag) begin
      fetch_pc_r <= branch_target & 32'hFFFF_FFFC;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        wr_ptr_r   <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: ROM word[i] = i, expected fetches queued by
// the stimulus and matched against every accepted output by a monitor.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  fifo_count;

  int total  = 0;
  int bad    = 0;
  int n_pops = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign rom_inst = {2'b00, rom_addr[31:2]};

  inst_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .branch_flag(branch_flag), .branch_target(branch_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted head entry must match the oldest queued fetch.
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && branch_flag === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got pc %h want no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", out_pc, e[63:32]);
          chk("pop_inst", out_inst, e[31:0]);
        end
      end
    end
  endtask

  // One normal cycle: check fetch side and occupancy, queue the fetched word.
  task automatic cyc(input logic ce, input logic [31:0] addr, input int cnt);
    @(negedge clk);
    chk("rom_ce", {31'd0, rom_ce}, {31'd0, ce});
    chk("rom_addr", rom_addr, ce ? addr : 32'h0);
    chk("fifo_count", {29'd0, fifo_count}, cnt);
    chk("out_valid", {31'd0, out_valid}, (cnt != 0) ? 32'd1 : 32'd0);
    if (cnt == 0) begin
      chk("empty_pc", out_pc, 32'h0);
      chk("empty_inst", out_inst, 32'h0);
    end
    if (ce) exp_q.push_back({addr, 2'b00, addr[31:2]});
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic branch(input logic [31:0] tgt);
    branch_flag   = 1'b1;
    branch_target = tgt;
    @(negedge clk);
    chk("br_rom_ce", {31'd0, rom_ce}, 32'd0);
    chk("br_rom_addr", rom_addr, 32'h0);
    @(posedge clk);
    #1;
    exp_q.delete();
    branch_flag = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    out_ready     = 1'b1;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;
    rst_cycle();
    rst = 1'b0;
    rst_cycle();

    // streaming with the consumer always ready
    cyc(1'b1, 32'h0, 0);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 32'(4 * k), 1);
    rst_cycle();

    // stall until full, then drain with no gap
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'(4 * k), k);
    for (int k = 4; k < 10; k++) cyc(1'b0, 32'h0, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'(16 + 4 * k), 4);

    // branch while full, with a handshake that must be discarded
    branch(32'h0000_0103);
    cyc(1'b1, 32'h0000_0100, 0);
    cyc(1'b1, 32'h0000_0104, 1);
    cyc(1'b1, 32'h0000_0108, 1);
    branch(32'h0000_0200);
    branch(32'h0000_0305);
    cyc(1'b1, 32'h0000_0304, 0);
    cyc(1'b1, 32'h0000_0308, 1);

    // fetch PC wrap at the top of the address space
    branch(32'hFFFF_FFF8);
    cyc(1'b1, 32'hFFFF_FFF8, 0);
    cyc(1'b1, 32'hFFFF_FFFC, 1);
    cyc(1'b1, 32'h0000_0000, 1);

    // alternating ready starting at two entries
    out_ready = 1'b0;
    branch(32'h0000_0040);
    cyc(1'b1, 32'h0000_0040, 0);
    cyc(1'b1, 32'h0000_0044, 1);
    out_ready = 1'b1; cyc(1'b1, 32'h0000_0048, 2);
    out_ready = 1'b0; cyc(1'b1, 32'h0000_004C, 2);
    out_ready = 1'b1; cyc(1'b1, 32'h0000_0050, 3);
    out_ready = 1'b0; cyc(1'b1, 32'h0000_0054, 3);
    out_ready = 1'b1; cyc(1'b1, 32'h0000_0058, 4);
    out_ready = 1'b0; cyc(1'b0, 32'h0, 4);
    out_ready = 1'b1; cyc(1'b1, 32'h0000_005C, 4);
    out_ready = 1'b0; cyc(1'b0, 32'h0, 4);

    // one-cycle reset with three entries buffered
    branch(32'h0000_0080);
    cyc(1'b1, 32'h0000_0080, 0);
    cyc(1'b1, 32'h0000_0084, 1);
    cyc(1'b1, 32'h0000_0088, 2);
    out_ready = 1'b1;
    rst_cycle();
    cyc(1'b1, 32'h0000_0000, 0);
    cyc(1'b1, 32'h0000_0004, 1);

    chk("pop_total", n_pops, 32'd20);
    chk("queue_left", exp_q.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
